// File: rtl/wb_stage_pkg.sv
// wb_stage_pkg: shared constants and types for the writeback stage.
//   - mem2 -> writeback bus width and field offsets
//   - forwarding bus width
//   - writeback FSM state encoding
//   - helper that qualifies a lane's register-file write
package wb_stage_pkg;

  // mem2 -> writeback bus: {lane_older, pc, dest, rf_we, wdata}
  localparam int M2S_TO_WS_BUS_WD = 71;
  // writeback -> forwarding bus: {valid, dest, wdata}
  localparam int WS_FWD_BUS       = 38;

  localparam int BUS_OLDER_BIT    = 70;
  localparam int BUS_PC_MSB       = 69;
  localparam int BUS_PC_LSB       = 38;
  localparam int BUS_DEST_MSB     = 37;
  localparam int BUS_DEST_LSB     = 33;
  localparam int BUS_RFWE_BIT     = 32;
  localparam int BUS_WDATA_MSB    = 31;
  localparam int BUS_WDATA_LSB    = 0;

  // S_FIRST: regfile writes + older trace entry; S_SECOND: younger trace entry only
  typedef enum logic [0:0] {
    S_FIRST  = 1'b0,
    S_SECOND = 1'b1
  } ws_state_e;

  // A lane really writes the regfile only if it holds an instruction,
  // that instruction writes, and the target is not the hardwired zero register.
  function automatic logic lane_writes(input logic       valid,
                                       input logic       rf_we,
                                       input logic [4:0] dest);
    return valid & rf_we & (dest != 5'd0);
  endfunction

endpackage

// File: rtl/wb_lane.sv
// wb_lane: one writeback lane.
//   Holds the lane's instruction register (loaded when the stage accepts a
//   pair, cleared when this lane's input is not valid), decodes its fields,
//   qualifies the regfile write and builds the lane's forwarding bus.
// Ports:
//   clk, resetn         clock, async active-low reset
//   load                stage accepts a new pair this cycle
//   in_valid, in_bus    lane input from mem2
//   valid, older        registered lane valid and lane_older flag
//   pc, dest, wdata     decoded instruction fields
//   wr                  qualified regfile write (valid & rf_we & dest!=0)
//   fwd_bus             {wr, dest, wdata} to forwarding
module wb_lane
  import wb_stage_pkg::*;
(
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        load,
  input  logic                        in_valid,
  input  logic [M2S_TO_WS_BUS_WD-1:0] in_bus,
  output logic                        valid,
  output logic                        older,
  output logic [31:0]                 pc,
  output logic [4:0]                  dest,
  output logic [31:0]                 wdata,
  output logic                        wr,
  output logic [WS_FWD_BUS-1:0]       fwd_bus
);

  logic                        valid_r;
  logic [M2S_TO_WS_BUS_WD-1:0] bus_r;

  // Lane instruction register; an invalid input clears the whole lane.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid_r <= 1'b0;
      bus_r   <= {M2S_TO_WS_BUS_WD{1'b0}};
    end else if (load) begin
      valid_r <= in_valid;
      bus_r   <= in_valid ? in_bus : {M2S_TO_WS_BUS_WD{1'b0}};
    end
  end

  assign valid   = valid_r;
  assign older   = bus_r[BUS_OLDER_BIT];
  assign pc      = bus_r[BUS_PC_MSB:BUS_PC_LSB];
  assign dest    = bus_r[BUS_DEST_MSB:BUS_DEST_LSB];
  assign wdata   = bus_r[BUS_WDATA_MSB:BUS_WDATA_LSB];
  assign wr      = lane_writes(valid_r, bus_r[BUS_RFWE_BIT], dest);
  // Held for the whole residency of the pair, including S_SECOND.
  assign fwd_bus = {wr, dest, wdata};

endmodule

// File: rtl/wb_stage.sv
// wb_stage: dual-lane writeback stage.
//   Accepts an instruction pair from mem2, writes both lanes to the regfile
//   in a single cycle (younger wins on a shared destination) and serialises
//   the trace port to one instruction per cycle, oldest first. A dual-issue
//   pair occupies the stage for two cycles, a single instruction for one.
// Ports:
//   clk, resetn                        clock, async active-low reset
//   m2s_to_ws_valid[1:0]               per-lane valid from mem2
//   m2s_to_ws_bus_0/1                  per-lane instruction bus from mem2
//   ws_allowin                         stage accepts a new pair this cycle
//   rf_we_n, rf_waddr_n, rf_wdata_n    regfile write ports per lane
//   ws_fwd_bus_0/1                     {valid, dest, wdata} to forwarding
//   debug_wb_pc/rf_wen/rf_wnum/rf_wdata trace port
module wb_stage
  import wb_stage_pkg::*;
(
  input  logic                        clk,
  input  logic                        resetn,
  input  logic [1:0]                  m2s_to_ws_valid,
  input  logic [M2S_TO_WS_BUS_WD-1:0] m2s_to_ws_bus_0,
  input  logic [M2S_TO_WS_BUS_WD-1:0] m2s_to_ws_bus_1,
  output logic                        ws_allowin,
  output logic                        rf_we_0,
  output logic                        rf_we_1,
  output logic [4:0]                  rf_waddr_0,
  output logic [4:0]                  rf_waddr_1,
  output logic [31:0]                 rf_wdata_0,
  output logic [31:0]                 rf_wdata_1,
  output logic [WS_FWD_BUS-1:0]       ws_fwd_bus_0,
  output logic [WS_FWD_BUS-1:0]       ws_fwd_bus_1,
  output logic [31:0]                 debug_wb_pc,
  output logic [3:0]                  debug_wb_rf_wen,
  output logic [4:0]                  debug_wb_rf_wnum,
  output logic [31:0]                 debug_wb_rf_wdata
);

  ws_state_e   state_r;
  ws_state_e   state_nxt_s;

  logic        l0_valid_s, l1_valid_s;
  logic        l0_older_unused_s, l1_older_s;
  logic [31:0] l0_pc_s, l1_pc_s;
  logic [4:0]  l0_dest_s, l1_dest_s;
  logic [31:0] l0_wdata_s, l1_wdata_s;
  logic        l0_wr_s, l1_wr_s;

  logic        any_s, both_s;
  logic        older_is_1_s;
  logic        same_dest_s;
  logic        trace_en_s;
  logic        trace_sel_1_s;

  wb_lane u_lane0 (
    .clk      (clk),
    .resetn   (resetn),
    .load     (ws_allowin),
    .in_valid (m2s_to_ws_valid[0]),
    .in_bus   (m2s_to_ws_bus_0),
    .valid    (l0_valid_s),
    .older    (l0_older_unused_s),
    .pc       (l0_pc_s),
    .dest     (l0_dest_s),
    .wdata    (l0_wdata_s),
    .wr       (l0_wr_s),
    .fwd_bus  (ws_fwd_bus_0)
  );

  wb_lane u_lane1 (
    .clk      (clk),
    .resetn   (resetn),
    .load     (ws_allowin),
    .in_valid (m2s_to_ws_valid[1]),
    .in_bus   (m2s_to_ws_bus_1),
    .valid    (l1_valid_s),
    .older    (l1_older_s),
    .pc       (l1_pc_s),
    .dest     (l1_dest_s),
    .wdata    (l1_wdata_s),
    .wr       (l1_wr_s),
    .fwd_bus  (ws_fwd_bus_1)
  );

  assign any_s  = l0_valid_s | l1_valid_s;
  assign both_s = l0_valid_s & l1_valid_s;
  // Lane 1 is treated as older when it is the only valid lane, so a lone
  // lane-1 instruction is emitted in S_FIRST regardless of its older flag.
  assign older_is_1_s = l1_valid_s & (l1_older_s | ~l0_valid_s);
  // Both lanes writing the same real register: only the younger may write.
  assign same_dest_s  = l0_wr_s & l1_wr_s & (l0_dest_s == l1_dest_s);

  assign rf_waddr_0 = l0_dest_s;
  assign rf_waddr_1 = l1_dest_s;
  assign rf_wdata_0 = l0_wdata_s;
  assign rf_wdata_1 = l1_wdata_s;

  // FSM state register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r <= S_FIRST;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next state: a dual pair needs a second cycle for the younger trace entry.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_FIRST: begin
        if (both_s) begin
          state_nxt_s = S_SECOND;
        end else begin
          state_nxt_s = S_FIRST;
        end
      end
      S_SECOND: state_nxt_s = S_FIRST;
      default:  state_nxt_s = S_FIRST;
    endcase
  end

  // Handshake, regfile write enables and trace-lane selection per state.
  always_comb begin
    ws_allowin    = 1'b1;
    rf_we_0       = 1'b0;
    rf_we_1       = 1'b0;
    trace_en_s    = 1'b0;
    trace_sel_1_s = 1'b0;
    case (state_r)
      S_FIRST: begin
        ws_allowin    = ~any_s | ~both_s;
        rf_we_0       = l0_wr_s & ~(same_dest_s & ~older_is_1_s);
        rf_we_1       = l1_wr_s & ~(same_dest_s &  older_is_1_s);
        trace_en_s    = any_s;
        trace_sel_1_s = older_is_1_s;
      end
      S_SECOND: begin
        ws_allowin    = 1'b1;
        trace_en_s    = both_s;
        trace_sel_1_s = ~older_is_1_s;
      end
      default: begin
        ws_allowin    = 1'b1;
        trace_en_s    = 1'b0;
        trace_sel_1_s = 1'b0;
      end
    endcase
  end

  // Trace port mux: selected lane's fields, zero when nothing to report.
  always_comb begin
    debug_wb_pc       = 32'd0;
    debug_wb_rf_wen   = 4'd0;
    debug_wb_rf_wnum  = 5'd0;
    debug_wb_rf_wdata = 32'd0;
    if (trace_en_s) begin
      if (trace_sel_1_s) begin
        debug_wb_pc       = l1_pc_s;
        debug_wb_rf_wen   = {4{l1_wr_s}};
        debug_wb_rf_wnum  = l1_dest_s;
        debug_wb_rf_wdata = l1_wdata_s;
      end else begin
        debug_wb_pc       = l0_pc_s;
        debug_wb_rf_wen   = {4{l0_wr_s}};
        debug_wb_rf_wnum  = l0_dest_s;
        debug_wb_rf_wdata = l0_wdata_s;
      end
    end else begin
      debug_wb_pc       = 32'd0;
      debug_wb_rf_wen   = 4'd0;
      debug_wb_rf_wnum  = 5'd0;
      debug_wb_rf_wdata = 32'd0;
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: directed + randomized bench for wb_stage against a
// queue-based reference model of the writeback stage.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        resetn;
  logic [1:0]  m2s_to_ws_valid;
  logic [70:0] m2s_to_ws_bus_0, m2s_to_ws_bus_1;
  logic        ws_allowin;
  logic        rf_we_0, rf_we_1;
  logic [4:0]  rf_waddr_0, rf_waddr_1;
  logic [31:0] rf_wdata_0, rf_wdata_1;
  logic [37:0] ws_fwd_bus_0, ws_fwd_bus_1;
  logic [31:0] debug_wb_pc;
  logic [3:0]  debug_wb_rf_wen;
  logic [4:0]  debug_wb_rf_wnum;
  logic [31:0] debug_wb_rf_wdata;

  wb_stage dut (
    .clk               (clk),
    .resetn            (resetn),
    .m2s_to_ws_valid   (m2s_to_ws_valid),
    .m2s_to_ws_bus_0   (m2s_to_ws_bus_0),
    .m2s_to_ws_bus_1   (m2s_to_ws_bus_1),
    .ws_allowin        (ws_allowin),
    .rf_we_0           (rf_we_0),
    .rf_we_1           (rf_we_1),
    .rf_waddr_0        (rf_waddr_0),
    .rf_waddr_1        (rf_waddr_1),
    .rf_wdata_0        (rf_wdata_0),
    .rf_wdata_1        (rf_wdata_1),
    .ws_fwd_bus_0      (ws_fwd_bus_0),
    .ws_fwd_bus_1      (ws_fwd_bus_1),
    .debug_wb_pc       (debug_wb_pc),
    .debug_wb_rf_wen   (debug_wb_rf_wen),
    .debug_wb_rf_wnum  (debug_wb_rf_wnum),
    .debug_wb_rf_wdata (debug_wb_rf_wdata)
  );

  always #5 clk = ~clk;

  // Reference model: instructions still to be traced, in program order.
  typedef struct {
    logic [31:0] pc;
    logic [4:0]  dest;
    logic        we;
    logic [31:0] wdata;
    int          lane;
    bit          suppressed;
  } ent_t;

  ent_t        q[$];
  bit          fresh;           // regfile writes of the queued pair not yet done
  logic [37:0] held_fwd [2];

  int compared = 0;
  int mismatched = 0;

  function automatic logic [70:0] mk(input logic older, input logic [31:0] pc,
                                     input logic [4:0] dest, input logic we,
                                     input logic [31:0] wdata);
    return {older, pc, dest, we, wdata};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    fresh = 1'b0;
    held_fwd[0] = 38'd0;
    held_fwd[1] = 38'd0;
  endtask

  task automatic check_outputs();
    logic       exp_we [2];
    logic       exp_allow;
    ent_t       e;
    exp_we[0] = 1'b0;
    exp_we[1] = 1'b0;
    exp_allow = (q.size() <= 1);
    if (fresh) begin
      foreach (q[i]) begin
        if (q[i].we && q[i].dest != 5'd0 && !q[i].suppressed) exp_we[q[i].lane] = 1'b1;
      end
    end
    chk("allowin", {63'd0, ws_allowin}, {63'd0, exp_allow});
    chk("rf_we_0", {63'd0, rf_we_0}, {63'd0, exp_we[0]});
    chk("rf_we_1", {63'd0, rf_we_1}, {63'd0, exp_we[1]});
    if (exp_we[0]) begin
      chk("rf_waddr_0", {59'd0, rf_waddr_0}, {59'd0, held_fwd[0][36:32]});
      chk("rf_wdata_0", {32'd0, rf_wdata_0}, {32'd0, held_fwd[0][31:0]});
    end
    if (exp_we[1]) begin
      chk("rf_waddr_1", {59'd0, rf_waddr_1}, {59'd0, held_fwd[1][36:32]});
      chk("rf_wdata_1", {32'd0, rf_wdata_1}, {32'd0, held_fwd[1][31:0]});
    end
    chk("fwd_0", {26'd0, ws_fwd_bus_0}, {26'd0, held_fwd[0]});
    chk("fwd_1", {26'd0, ws_fwd_bus_1}, {26'd0, held_fwd[1]});
    if (q.size() > 0) begin
      e = q[0];
      chk("trace_pc",    {32'd0, debug_wb_pc},       {32'd0, e.pc});
      chk("trace_wen",   {60'd0, debug_wb_rf_wen},   {60'd0, {4{e.we && e.dest != 5'd0}}});
      chk("trace_wnum",  {59'd0, debug_wb_rf_wnum},  {59'd0, e.dest});
      chk("trace_wdata", {32'd0, debug_wb_rf_wdata}, {32'd0, e.wdata});
    end else begin
      chk("trace_idle", {27'd0, debug_wb_pc, debug_wb_rf_wen}, 64'd0);
      chk("trace_idle_d", {27'd0, debug_wb_rf_wnum, debug_wb_rf_wdata}, 64'd0);
    end
  endtask

  // Advance the model across one rising edge with the given inputs.
  task automatic model_advance(input logic [1:0] v, input logic [70:0] b0, input logic [70:0] b1);
    bit   allow;
    ent_t e [2];
    allow = (q.size() <= 1);
    if (q.size() > 0) void'(q.pop_front());
    fresh = 1'b0;
    if (allow) begin
      for (int n = 0; n < 2; n++) begin
        logic [70:0] b;
        b = (n == 0) ? b0 : b1;
        e[n].pc = b[69:38]; e[n].dest = b[37:33]; e[n].we = b[32];
        e[n].wdata = b[31:0]; e[n].lane = n; e[n].suppressed = 1'b0;
        held_fwd[n] = v[n] ? {b[32] && b[37:33] != 5'd0, b[37:33], b[31:0]} : 38'd0;
      end
      if (v == 2'b11) begin
        int o;
        o = b1[70] ? 1 : 0;
        if (e[0].we && e[1].we && e[0].dest != 5'd0 && e[0].dest == e[1].dest)
          e[o].suppressed = 1'b1;
        q.push_back(e[o]);
        q.push_back(e[1 - o]);
      end else if (v == 2'b01) begin
        q.push_back(e[0]);
      end else if (v == 2'b10) begin
        q.push_back(e[1]);
      end
      fresh = (v != 2'b00);
    end
  endtask

  task automatic step(input logic [1:0] v, input logic [70:0] b0, input logic [70:0] b1);
    @(negedge clk);
    check_outputs();
    m2s_to_ws_valid = v;
    m2s_to_ws_bus_0 = b0;
    m2s_to_ws_bus_1 = b1;
    model_advance(v, b0, b1);
  endtask

  initial begin
    resetn = 1'b0;
    m2s_to_ws_valid = 2'b00;
    m2s_to_ws_bus_0 = 71'd0;
    m2s_to_ws_bus_1 = 71'd0;
    model_reset();

    // Reset state
    @(negedge clk);
    check_outputs();
    #2 resetn = 1'b1;

    // Single lane 0 write
    step(2'b01, mk(1'b0, 32'hBFC0_0000, 5'd3, 1'b1, 32'h1234), 71'd0);
    // Dual, lane 1 older
    step(2'b11, mk(1'b0, 32'h104, 5'd5, 1'b1, 32'h55), mk(1'b1, 32'h100, 5'd4, 1'b1, 32'h44));
    step(2'b00, 71'd0, 71'd0);
    // Dual same dest, lane 0 older -> only lane 1 writes
    step(2'b11, mk(1'b0, 32'h200, 5'd7, 1'b1, 32'hA), mk(1'b0, 32'h204, 5'd7, 1'b1, 32'hB));
    step(2'b00, 71'd0, 71'd0);
    // dest=0 with rf_we=1
    step(2'b01, mk(1'b0, 32'h300, 5'd0, 1'b1, 32'hDEAD), 71'd0);
    // Lone lane 1 with older flag clear
    step(2'b10, 71'd0, mk(1'b0, 32'h400, 5'd9, 1'b1, 32'h99));
    step(2'b00, 71'd0, 71'd0);
    step(2'b00, 71'd0, 71'd0);

    // Reset asserted during S_SECOND
    step(2'b11, mk(1'b1, 32'h500, 5'd10, 1'b1, 32'h10), mk(1'b0, 32'h504, 5'd11, 1'b1, 32'h11));
    step(2'b00, 71'd0, 71'd0);     // S_FIRST of the pair checked here
    @(negedge clk);                // now in S_SECOND
    #2 resetn = 1'b0;
    #1;
    model_reset();
    check_outputs();
    #1 resetn = 1'b1;
    step(2'b00, 71'd0, 71'd0);
    step(2'b00, 71'd0, 71'd0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic [1:0] v;
      v = 2'($urandom_range(0, 3));
      step(v,
           mk(1'($urandom), $urandom, 5'($urandom_range(0, 7)), 1'($urandom), $urandom),
           mk(1'($urandom), $urandom, 5'($urandom_range(0, 7)), 1'($urandom), $urandom));
    end
    step(2'b00, 71'd0, 71'd0);
    step(2'b00, 71'd0, 71'd0);
    step(2'b00, 71'd0, 71'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 SHALL expose clk  in  1  single clock; all state on rising edge.
REQ-002 SHALL expose resetn  in  1  asynchronous, active-low reset.
REQ-003 SHALL expose m2s_to_ws_valid  in  2  per-lane valid from mem2 stage.
REQ-004 SHALL expose m2s_to_ws_bus_0, m2s_to_ws_bus_1  in  `M2S_TO_WS_BUS_WD (71)  fields: [70] lane_older (lane 1 only), [69:38] pc, [37:33] dest, [32] rf_we, [31:0] wdata.
REQ-005 SHALL expose ws_allowin  out  1  stage accepts new pair this cycle.
REQ-006 SHALL expose rf_we_0/rf_we_1  out  1, rf_waddr_0/1  out  5, rf_wdata_0/1  out  32  regfile write ports.
REQ-007 SHALL expose ws_fwd_bus_0, ws_fwd_bus_1  out  `WS_FWD_BUS (38)  {valid, dest[4:0], wdata[31:0]} to forwarding.
REQ-008 SHALL expose debug_wb_pc  out  32, debug_wb_rf_wen  out  4, debug_wb_rf_wnum  out  5, debug_wb_rf_wdata  out  32  trace port, one instruction per cycle.

Function
REQ-009 SHALL register valid[1:0] and both buses when ws_allowin=1; lane register cleared to 0 when its input valid is 0.
REQ-010 SHALL define older lane = lane 1 if valid[1] and bus_1[70]=1, else lane 0; younger = the other.
REQ-011 SHALL implement FSM {S_FIRST, S_SECOND}: S_FIRST -> S_SECOND when both lanes valid; S_SECOND -> S_FIRST unconditionally next cycle.
REQ-012 SHALL drive ws_allowin = !(valid[0]|valid[1]) | (state==S_FIRST & !(valid[0]&valid[1])) | state==S_SECOND.
REQ-013 SHALL issue regfile writes for both lanes only in S_FIRST (each instruction written exactly once): rf_we_n = valid[n] & rf_we & dest!=0.
REQ-014 SHALL, when both lanes write the same nonzero dest, suppress the older lane's rf_we (younger wins).
REQ-015 SHALL drive trace in S_FIRST with older lane, in S_SECOND with younger lane; debug_wb_rf_wen = {4{lane rf_we & dest!=0}}; trace fields zero when no valid lane.
REQ-016 SHALL drive ws_fwd_bus_n valid = valid[n] & rf_we & dest!=0, held unchanged through both S_FIRST and S_SECOND.
REQ-017 SHALL have latency 1 cycle (single issue) or 2 cycles (dual issue) from acceptance to ws_allowin=1 again.
REQ-018 SHALL, in S_SECOND, perform no regfile writes.
REQ-019 SHALL, with single lane 1 valid only, emit that lane in S_FIRST and remain in S_FIRST.

Reset
REQ-020 SHALL on resetn=0 asynchronously clear valid, lane registers, state to S_FIRST; all outputs 0 except ws_allowin=1.
REQ-021 SHALL, on reset asserted during S_SECOND, drop the pending younger trace entry with no regfile write.

Structure
REQ-022 SHALL take `M2S_TO_WS_BUS_WD, `WS_FWD_BUS, field offsets and FSM state encodings from shared mycpu.h.
REQ-023 SHALL instantiate one sub-module wb_lane (per-lane field decode, rf_we qualification, fwd bus) twice; FSM and arbitration in wb_stage.

Verification
REQ-024 Single lane 0: pc=0xBFC00000, dest=3, wdata=0x1234, rf_we=1 -> next cycle rf_we_0=1, waddr=3, trace pc=0xBFC00000, wen=0xF; ws_allowin stays 1.
REQ-025 Dual, lane1 older (pc 0x100 dest 4) lane0 (pc 0x104 dest 5) -> cycle1 both writes, trace 0x100, ws_allowin=0; cycle2 trace 0x104, no writes, ws_allowin=1.
REQ-026 Dual same dest 7, lane0 older wdata 0xA, lane1 younger 0xB -> only rf_we_1=1 wdata 0xB; trace shows both in order 0xA, 0xB.
REQ-027 dest=0 with rf_we=1 -> rf_we=0, debug_wb_rf_wen=0, fwd valid=0; trace pc still emitted.
REQ-028 resetn low during S_SECOND -> immediately outputs 0, ws_allowin=1; after release no trace of younger entry.
